// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit that owns the HI/LO register pair.
// MULT/MULTU use a shift-add loop and DIV/DIVU use a restoring loop.
// Both produce one bit per cycle and hold the pipeline through busy.
// MTHI/MTLO writes are accepted only while the unit is idle.
//
// Optional feature: define MULDIV_EARLY_OUT_EN to let multiplies leave RUN
// as soon as the remaining multiplier bits are zero.
//
// Ports:
//   i_clk, i_rst       clock (rising edge), asynchronous active-high reset
//   i_start            launch an operation (sampled in IDLE only)
//   i_op               00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_op1, i_op2       multiplicand/dividend, multiplier/divisor
//   i_mthi, i_mtlo     write i_wdata into HI / LO
//   i_wdata            MTHI/MTLO data
//   o_busy             operation in progress (stall request)
//   o_done             one-cycle pulse after HI/LO are updated by an operation
//   o_dz               divide-by-zero flag, valid with o_done
//   o_hi, o_lo         HI and LO registers
module muldiv_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_op1,
  input  logic [DATA_W-1:0] i_op2,
  input  logic              i_mthi,
  input  logic              i_mtlo,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_dz,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t              state;
  logic [1:0]          op_q;
  logic [DATA_W-1:0]   op1_q;
  logic [DATA_W-1:0]   op2_q;
  logic                neg_q;    // product / quotient sign
  logic                neg_r;    // remainder sign
  logic                dz_q;
  logic [PROD_W-1:0]   mcand;    // multiplicand, shifted left each step
  logic [DATA_W-1:0]   mplier;   // multiplier (shifted right) or divisor (static)
  logic [PROD_W-1:0]   prod;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   quo;      // dividend shifts out as quotient bits shift in
  logic [CNT_W-1:0]    cnt;

  logic                signed_op;
  logic                is_div;
  logic                sign1;
  logic                sign2;
  logic [DATA_W-1:0]   mag1;
  logic [DATA_W-1:0]   mag2;
  logic [PROD_W-1:0]   prod_add;
  logic [DATA_W:0]     rem_sh;
  logic [DATA_W:0]     diff;
  logic                last;
  logic                early;
  logic [PROD_W-1:0]   prod_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  // Operand magnitudes, per-step datapath and sign-corrected results
  always_comb begin
    signed_op = ~op_q[0];
    is_div    = op_q[1];
    sign1     = signed_op & op1_q[DATA_W-1];
    sign2     = signed_op & op2_q[DATA_W-1];
    mag1      = sign1 ? -op1_q : op1_q;
    mag2      = sign2 ? -op2_q : op2_q;
    prod_add  = prod + (mplier[0] ? mcand : {PROD_W{1'b0}});
    // Working remainder is DATA_W+1 bits so the trial subtract's borrow is visible
    rem_sh    = {rem, quo[DATA_W-1]};
    diff      = rem_sh - {1'b0, mplier};
    last      = (cnt == CNT_W'(DATA_W - 1));
`ifdef MULDIV_EARLY_OUT_EN
    early     = ~is_div && ((mplier >> 1) == {DATA_W{1'b0}});
`else
    early     = 1'b0;
`endif
    prod_fix  = neg_q ? -prod : prod;
    quo_fix   = neg_q ? -quo : quo;
    rem_fix   = neg_r ? -rem : rem;
  end

  // Sequencer with registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      op_q   <= 2'b00;
      op1_q  <= '0;
      op2_q  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz_q   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      rem    <= '0;
      quo    <= '0;
      cnt    <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_dz   <= 1'b0;
      o_hi   <= '0;
      o_lo   <= '0;
    end else begin
      o_done <= 1'b0;
      o_dz   <= 1'b0;
      case (state)
        IDLE: begin
          // A start wins over a same-cycle MTHI/MTLO
          if (i_start) begin
            op_q   <= i_op;
            op1_q  <= i_op1;
            op2_q  <= i_op2;
            o_busy <= 1'b1;
            state  <= PREP;
          end else begin
            if (i_mthi) o_hi <= i_wdata;
            if (i_mtlo) o_lo <= i_wdata;
          end
        end
        PREP: begin
          neg_q  <= sign1 ^ sign2;
          neg_r  <= sign1;
          mcand  <= {{DATA_W{1'b0}}, mag1};
          mplier <= mag2;
          prod   <= '0;
          rem    <= '0;
          quo    <= mag1;
          cnt    <= '0;
          if (is_div && (op2_q == {DATA_W{1'b0}})) begin
            dz_q  <= 1'b1;
            state <= FIX;
          end else begin
            dz_q  <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          if (is_div) begin
            // Restoring step: keep the difference only if it did not borrow
            if (!diff[DATA_W]) begin
              rem <= diff[DATA_W-1:0];
              quo <= {quo[DATA_W-2:0], 1'b1};
            end else begin
              rem <= rem_sh[DATA_W-1:0];
              quo <= {quo[DATA_W-2:0], 1'b0};
            end
          end else begin
            prod   <= prod_add;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
          cnt <= cnt + CNT_W'(1);
          if (last || early) state <= FIX;
        end
        FIX: begin
          if (dz_q) begin
            o_hi <= op1_q;
            o_lo <= {DATA_W{1'b1}};
          end else if (is_div) begin
            o_hi <= rem_fix;
            o_lo <= quo_fix;
          end else begin
            o_hi <= prod_fix[PROD_W-1:DATA_W];
            o_lo <= prod_fix[DATA_W-1:0];
          end
          o_dz   <= dz_q;
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed operations push expected
// HI/LO/dz results, a monitor pops and compares on every o_done pulse.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        dz;
  logic [31:0] hi;
  logic [31:0] lo;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  muldiv_sequencer #(.DATA_W(32), .CNT_W(6)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_start(start),
    .i_op   (op),
    .i_op1  (op1),
    .i_op2  (op2),
    .i_mthi (mthi),
    .i_mtlo (mtlo),
    .i_wdata(wdata),
    .o_busy (busy),
    .o_done (done),
    .o_dz   (dz),
    .o_hi   (hi),
    .o_lo   (lo)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  // Busy length of a multiply: with early-out, RUN lasts up to the top set multiplier bit
  function automatic int mul_busy(input logic [31:0] mag);
    int run;
    run = 1;
    for (int i = 0; i < 32; i++) if (mag[i]) run = i + 1;
`ifdef MULDIV_EARLY_OUT_EN
    return run + 2;
`else
    return (run > 0) ? 34 : 0;
`endif
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        e = sb.pop_front();
        chk({e.name, "_hi"}, hi, e.hi);
        chk({e.name, "_lo"}, lo, e.lo);
        chk({e.name, "_dz"}, 32'(dz), 32'(e.dz));
      end
    end
    if (!rst && dz && !done) chk("dz_without_done", 32'(dz), 32'(0));
  end

  // Launch one operation, queue its expected result and measure busy length
  task automatic do_op(input logic [1:0] t_op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                       input int ebusy, input logic with_mt, input string name);
    int n;
    @(negedge clk);
    start = 1'b1;
    op    = t_op;
    op1   = a;
    op2   = b;
    if (with_mt) begin
      mthi  = 1'b1;
      mtlo  = 1'b1;
      wdata = 32'h0000AAAA;
    end
    sb.push_back('{ehi, elo, edz, name});
    @(posedge clk);
    if (with_mt) begin
      #1;
      chk("start_prio_hi", hi, 32'h00001234);
      chk("start_prio_lo", lo, 32'h00005678);
      chk("start_prio_busy", 32'(busy), 32'(1));
    end
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      start = 1'b0;
      mthi  = 1'b0;
      mtlo  = 1'b0;
      if (!busy) break;
      n++;
    end
    chk({name, "_busy_cycles"}, 32'(n), 32'(ebusy));
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; op = 2'b00; op1 = '0; op2 = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_dz", 32'(dz), 32'(0));
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    rst = 1'b0;

    // MTHI then MTLO while idle
    @(negedge clk); mthi = 1'b1; wdata = 32'h00001234;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b1; wdata = 32'h00005678;
    chk("mthi", hi, 32'h00001234);
    @(negedge clk); mtlo = 1'b0;
    chk("mtlo", lo, 32'h00005678);
    chk("mtlo_hi_kept", hi, 32'h00001234);

    // Start with MTHI/MTLO in the same cycle: writes dropped
    do_op(MULTU, 32'd2, 32'd3, 32'h0, 32'h6, 1'b0, mul_busy(32'd3), 1'b1, "multu_2x3");

    do_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0,
          mul_busy(32'hFFFFFFFF), 1'b0, "multu_max");
    do_op(MULT, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0,
          mul_busy(32'd7), 1'b0, "mult_m3x7");
    do_op(MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0,
          mul_busy(32'h80000000), 1'b0, "mult_min_sq");
    do_op(MULTU, 32'd5, 32'd3, 32'h0, 32'd15, 1'b0, mul_busy(32'd3), 1'b0, "multu_5x3");
    do_op(MULTU, 32'h12345678, 32'h0, 32'h0, 32'h0, 1'b0, mul_busy(32'h0), 1'b0, "multu_x0");
    do_op(DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 1'b0, "div_m7_2");
    do_op(DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34, 1'b0, "div_7_m2");
    do_op(DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1, 2, 1'b0, "divu_by0");
    do_op(DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 2, 1'b0, "div_by0");
    do_op(DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34, 1'b0, "div_ovf");
    do_op(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 1'b0, "divu_100_7");

    // Disturb inputs mid-RUN: result and held HI/LO must be unaffected
    @(negedge clk);
    start = 1'b1; op = MULTU; op1 = 32'h00010000; op2 = 32'h00010000;
    sb.push_back('{32'h1, 32'h0, 1'b0, "multu_disturb"});
    @(posedge clk);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      if (!busy) break;
      n++;
      if (n == 6) begin
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEADBEEF;
        op = MULT; op1 = 32'hFFFFFFFF; op2 = 32'hFFFFFFFF;
      end
      if (n == 7) begin
        chk("held_hi", hi, 32'd2);
        chk("held_lo", lo, 32'd14);
      end
    end
    chk("multu_disturb_busy_cycles", 32'(n), 32'(mul_busy(32'h00010000)));

    // Asynchronous reset in the middle of RUN
    @(negedge clk); mthi = 1'b1; wdata = 32'h00000077;
    @(negedge clk); mthi = 1'b0;
    start = 1'b1; op = DIVU; op1 = 32'd1000; op2 = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    chk("pre_rst_busy", 32'(busy), 32'(1));
    chk("pre_rst_hi", hi, 32'h00000077);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'(0));
    chk("async_rst_hi", hi, 32'h0);
    chk("async_rst_lo", lo, 32'h0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'(0));

    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit beside the execute stage; owns the HI/LO register pair.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles, one bit per cycle, and holds the pipeline via o_busy.
- Serves MTHI/MTLO writes and MFHI/MFLO reads (o_hi/o_lo) for the pipeline.

Parameters:
- DATA_W, 32, operand width; HI/LO are DATA_W each, product 2*DATA_W.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  launch operation; sampled only in IDLE.
- i_op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- i_op1  input  DATA_W  multiplicand / dividend (rs).
- i_op2  input  DATA_W  multiplier / divisor (rt).
- i_mthi  input  1  write i_wdata to HI.
- i_mtlo  input  1  write i_wdata to LO.
- i_wdata  input  DATA_W  MTHI/MTLO data.
- o_busy  output  1  operation in progress; pipeline stall request.
- o_done  output  1  one-cycle pulse; HI/LO just updated by an operation.
- o_dz  output  1  divide-by-zero flag; valid while o_done=1, else 0.
- o_hi  output  DATA_W  HI register.
- o_lo  output  DATA_W  LO register.

Behaviour:
- Reset (async, any state): state=IDLE; o_busy=0, o_done=0, o_dz=0, o_hi=0, o_lo=0; internal counter/accumulators cleared.
- States: IDLE, PREP, RUN, FIX.
- IDLE:
  - i_start=1 -> latch i_op, i_op1, i_op2; go to PREP; o_busy=1 from the next cycle.
  - i_start has priority: i_mthi/i_mtlo in the same cycle are dropped.
  - Otherwise i_mthi/i_mtlo write HI/LO at the edge. Both may be asserted together.
- PREP (1 cycle):
  - Signed ops: take the magnitude of each operand and record result signs.
  - Quotient and product sign = sign1 XOR sign2. Remainder sign = dividend sign.
  - Clear counter.
  - DIV/DIVU with divisor 0 -> FIX directly, skipping RUN. Otherwise -> RUN.
- RUN (DATA_W cycles; counter 0..DATA_W-1; last count -> FIX):
  - Multiply: shift-add, 2*DATA_W-bit unsigned accumulator.
  - Divide: restoring, one quotient bit per cycle; remainder DATA_W+1 bits wide.
- FIX (1 cycle):
  - Apply sign correction (two's-complement negate where required).
  - Write HI/LO: MULT/MULTU HI=product[2W-1:W], LO=product[W-1:0]; DIV/DIVU HI=remainder, LO=quotient.
  - Divide-by-zero: HI=latched dividend, LO=all ones, o_dz=1.
  - Go to IDLE; o_done=1 for exactly the following cycle.
- Latency (DATA_W=32):
  - Start edge E0: o_busy=1 after E0 and stays high for 34 cycles.
  - After E0+34: o_busy=0, o_done=1, new HI/LO visible.
  - Divide-by-zero: o_busy for 2 cycles; done after E0+2.
- Back-to-back: i_start sampled in the o_done cycle is accepted, so done and busy can be seen in adjacent cycles.
- While busy:
  - i_start, i_mthi, i_mtlo are ignored; latched operands are unaffected by input changes.
  - o_hi/o_lo hold their old values until the FIX edge.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, o_dz=0; no trap.
- No cancel input; only i_rst aborts an operation mid-flight, with HI/LO returning to 0.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: in RUN for MULT/MULTU, when the remaining shifted-multiplier bits are all zero, jump to FIX at that edge; accumulator is already final.
  - Multiplier 0 after PREP -> RUN lasts 1 cycle.
  - Divide latency unchanged.
- Undefined: fixed DATA_W RUN cycles for every operation; latency exactly as stated above.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 34 busy cycles: o_done=1, HI=0xFFFFFFFE, LO=0x00000001.
- MULT -3 x 7 (0xFFFFFFFD, 0x00000007) -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/0 -> busy 2 cycles, o_dz=1 with o_done, HI=100, LO=0xFFFFFFFF. DIV 0x80000000/-1 -> LO=0x80000000, HI=0, o_dz=0.
- MTHI 0x1234 and MTLO 0x5678 in IDLE -> o_hi=0x1234, o_lo=0x5678 next cycle. Repeat with i_start also high -> HI/LO untouched, busy rises.
- i_start, i_mtlo pulsed and operands changed mid-RUN -> no effect on result. Assert i_rst at RUN count 10 -> o_busy=0, o_hi=o_lo=0 immediately, without waiting for a clock edge.
- With MULDIV_EARLY_OUT_EN: MULTU 5 x 3 -> done well before 34 cycles, LO=15, HI=0. Without the macro -> exactly 34 busy cycles.
